// File: rtl/neosd_cmd_engine.sv
// neosd_cmd_engine: SD CMD-line engine. Serialises 48-bit commands (optional
// hardware CRC7), receives short/long responses as 32-bit words over a
// valid/ack handshake, checks response CRC7 and end bit, and enforces an
// NCR response timeout followed by a configurable clock tail.
module neosd_cmd_engine #(
  parameter int NCR_MAX   = 64,
  parameter int TAIL_CLKS = 8,
  parameter bit CRC_GEN   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        clkstrb_i,
  input  logic        sd_clk_en_i,
  input  logic [5:0]  cmd_idx_i,
  input  logic [31:0] cmd_arg_i,
  input  logic [6:0]  cmd_crc_i,
  input  logic        ctrl_start_i,
  input  logic [1:0]  ctrl_rmode_i,
  input  logic [1:0]  ctrl_dmode_i,
  output logic [31:0] resp_data_o,
  output logic [5:0]  resp_idx_o,
  output logic        resp_valid_o,
  input  logic        resp_ack_i,
  output logic        status_idle_o,
  output logic        err_timeout_o,
  output logic        err_crc_o,
  output logic        err_end_o,
  output logic        start_dat_o,
  output logic        sd_clk_req_o,
  output logic        sd_clk_stall_o,
  output logic        sd_cmd_oe,
  output logic        sd_cmd_o,
  input  logic        sd_cmd_i
);

  localparam int TW = $clog2(NCR_MAX + 1);
  localparam int LW = $clog2(TAIL_CLKS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WAIT, S_READ, S_REGOUT, S_TAIL
  } state_t;

  // One serial CRC7 step, polynomial x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // CRC7 over the 40 leading command bits, MSB first.
  function automatic logic [6:0] crc7_cmd(input logic [39:0] data);
    logic [6:0] c;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      c = crc7_step(c, data[i]);
    end
    return c;
  endfunction

  state_t         state_r;
  logic [46:0]    tx_sreg_r;
  logic [7:0]     bit_cnt_r;
  logic [TW-1:0]  tmo_cnt_r;
  logic [LW-1:0]  tail_cnt_r;
  logic [1:0]     rmode_r;
  logic [1:0]     dmode_r;
  logic [30:0]    word_r;
  logic [6:0]     crc_r;

  logic           b_s;
  logic [39:0]    hdr_s;
  logic [6:0]     crc_sel_s;
  logic [47:0]    frame_s;
  logic           long_s;
  logic           chk_s;
  logic           wr_pulse_s;
  logic           crc_en_s;
  logic           word_done_s;
  logic           last_s;

  assign b_s = clkstrb_i & sd_clk_en_i & sd_clk_req_o;

  // Build the outgoing command frame from the live inputs (latched on start).
  always_comb begin
    hdr_s = {2'b01, cmd_idx_i, cmd_arg_i};
    if (CRC_GEN) begin
      crc_sel_s = crc7_cmd(hdr_s);
    end else begin
      crc_sel_s = cmd_crc_i;
    end
    frame_s = {hdr_s, crc_sel_s, 1'b1};
  end

  // Decode response bit position: CRC window, word boundaries, last bit.
  // Position 0 is the first bit after the start bit.
  always_comb begin
    long_s     = (rmode_r == 2'd2);
    chk_s      = (rmode_r != 2'd3);
    wr_pulse_s = (dmode_r == 2'd1) || (dmode_r == 2'd3);
    if (long_s) begin
      crc_en_s    = (bit_cnt_r >= 8'd7) && (bit_cnt_r <= 8'd126);
      word_done_s = (bit_cnt_r == 8'd38) || (bit_cnt_r == 8'd70) ||
                    (bit_cnt_r == 8'd102) || (bit_cnt_r == 8'd134);
      last_s      = (bit_cnt_r == 8'd134);
    end else begin
      crc_en_s    = (bit_cnt_r <= 8'd38);
      word_done_s = (bit_cnt_r == 8'd38);
      last_s      = (bit_cnt_r == 8'd46);
    end
  end

  // Main engine FSM with all outputs registered; advances only on clkstrb_i.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r        <= S_IDLE;
      tx_sreg_r      <= 47'd0;
      bit_cnt_r      <= 8'd0;
      tmo_cnt_r      <= '0;
      tail_cnt_r     <= '0;
      rmode_r        <= 2'd0;
      dmode_r        <= 2'd0;
      word_r         <= 31'd0;
      crc_r          <= 7'd0;
      resp_data_o    <= 32'd0;
      resp_idx_o     <= 6'd0;
      resp_valid_o   <= 1'b0;
      status_idle_o  <= 1'b1;
      err_timeout_o  <= 1'b0;
      err_crc_o      <= 1'b0;
      err_end_o      <= 1'b0;
      start_dat_o    <= 1'b0;
      sd_clk_req_o   <= 1'b0;
      sd_clk_stall_o <= 1'b0;
      sd_cmd_oe      <= 1'b0;
      sd_cmd_o       <= 1'b1;
    end else if (clkstrb_i) begin
      start_dat_o <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (ctrl_start_i) begin
            rmode_r       <= ctrl_rmode_i;
            dmode_r       <= ctrl_dmode_i;
            tx_sreg_r     <= frame_s[46:0];
            sd_cmd_o      <= frame_s[47];
            bit_cnt_r     <= 8'd0;
            err_timeout_o <= 1'b0;
            err_crc_o     <= 1'b0;
            err_end_o     <= 1'b0;
            sd_cmd_oe     <= 1'b1;
            sd_clk_req_o  <= 1'b1;
            status_idle_o <= 1'b0;
            state_r       <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (b_s) begin
            if (bit_cnt_r == 8'd47) begin
              sd_cmd_oe <= 1'b0;
              sd_cmd_o  <= 1'b1;
              if (dmode_r == 2'd2) begin
                start_dat_o <= 1'b1;
              end
              if (rmode_r == 2'd0) begin
                tail_cnt_r <= '0;
                state_r    <= S_TAIL;
                if (wr_pulse_s) begin
                  start_dat_o <= 1'b1;
                end
              end else begin
                tmo_cnt_r <= '0;
                state_r   <= S_WAIT;
              end
            end else begin
              sd_cmd_o  <= tx_sreg_r[46];
              tx_sreg_r <= {tx_sreg_r[45:0], 1'b0};
              bit_cnt_r <= bit_cnt_r + 8'd1;
            end
          end
        end
        S_WAIT: begin
          if (b_s) begin
            if (!sd_cmd_i) begin
              bit_cnt_r <= 8'd0;
              crc_r     <= 7'd0;
              state_r   <= S_READ;
            end else begin
              if (tmo_cnt_r != TW'(NCR_MAX)) begin
                tmo_cnt_r <= tmo_cnt_r + TW'(1);
              end
              if (tmo_cnt_r == TW'(NCR_MAX - 1)) begin
                err_timeout_o <= 1'b1;
                tail_cnt_r    <= '0;
                state_r       <= S_TAIL;
              end
            end
          end
        end
        S_READ: begin
          if (b_s) begin
            word_r    <= {word_r[29:0], sd_cmd_i};
            bit_cnt_r <= bit_cnt_r + 8'd1;
            if (crc_en_s) begin
              crc_r <= crc7_step(crc_r, sd_cmd_i);
            end
            if (!long_s && (bit_cnt_r == 8'd6)) begin
              resp_idx_o <= {word_r[4:0], sd_cmd_i};
            end
            if (last_s) begin
              err_end_o <= ~sd_cmd_i;
              err_crc_o <= chk_s && (crc_r != word_r[6:0]);
            end
            if (word_done_s) begin
              resp_data_o    <= {word_r, sd_cmd_i};
              resp_valid_o   <= 1'b1;
              sd_clk_stall_o <= 1'b1;
              state_r        <= S_REGOUT;
            end else if (last_s) begin
              tail_cnt_r <= '0;
              state_r    <= S_TAIL;
              if (wr_pulse_s) begin
                start_dat_o <= 1'b1;
              end
            end
          end
        end
        S_REGOUT: begin
          if (resp_ack_i) begin
            resp_valid_o   <= 1'b0;
            sd_clk_stall_o <= 1'b0;
            if (long_s && (bit_cnt_r == 8'd135)) begin
              tail_cnt_r <= '0;
              state_r    <= S_TAIL;
              if (wr_pulse_s) begin
                start_dat_o <= 1'b1;
              end
            end else begin
              state_r <= S_READ;
            end
          end
        end
        S_TAIL: begin
          if (b_s) begin
            if (tail_cnt_r == LW'(TAIL_CLKS - 1)) begin
              sd_clk_req_o  <= 1'b0;
              status_idle_o <= 1'b1;
              state_r       <= S_IDLE;
            end else begin
              tail_cnt_r <= tail_cnt_r + LW'(1);
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neosd_cmd_engine.sv
// Testbench for neosd_cmd_engine: table of transactions driven against an
// SD card model, response words checked through a scoreboard queue.
module tb_neosd_cmd_engine;

  localparam int NCR  = 64;
  localparam int TAIL = 8;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        clkstrb_i = 1'b0;
  logic        sd_clk_en_i = 1'b0;
  logic [5:0]  cmd_idx_i = 6'd0;
  logic [31:0] cmd_arg_i = 32'd0;
  logic [6:0]  cmd_crc_i = 7'd0;
  logic        ctrl_start_i = 1'b0;
  logic [1:0]  ctrl_rmode_i = 2'd0;
  logic [1:0]  ctrl_dmode_i = 2'd0;
  logic [31:0] resp_data_o;
  logic [5:0]  resp_idx_o;
  logic        resp_valid_o;
  logic        resp_ack_i = 1'b0;
  logic        status_idle_o;
  logic        err_timeout_o;
  logic        err_crc_o;
  logic        err_end_o;
  logic        start_dat_o;
  logic        sd_clk_req_o;
  logic        sd_clk_stall_o;
  logic        sd_cmd_oe;
  logic        sd_cmd_o;
  logic        sd_cmd_i = 1'b1;

  neosd_cmd_engine #(.NCR_MAX(NCR), .TAIL_CLKS(TAIL), .CRC_GEN(1'b1)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .clkstrb_i(clkstrb_i), .sd_clk_en_i(sd_clk_en_i),
    .cmd_idx_i(cmd_idx_i), .cmd_arg_i(cmd_arg_i), .cmd_crc_i(cmd_crc_i),
    .ctrl_start_i(ctrl_start_i), .ctrl_rmode_i(ctrl_rmode_i), .ctrl_dmode_i(ctrl_dmode_i),
    .resp_data_o(resp_data_o), .resp_idx_o(resp_idx_o), .resp_valid_o(resp_valid_o),
    .resp_ack_i(resp_ack_i), .status_idle_o(status_idle_o), .err_timeout_o(err_timeout_o),
    .err_crc_o(err_crc_o), .err_end_o(err_end_o), .start_dat_o(start_dat_o),
    .sd_clk_req_o(sd_clk_req_o), .sd_clk_stall_o(sd_clk_stall_o), .sd_cmd_oe(sd_cmd_oe),
    .sd_cmd_o(sd_cmd_o), .sd_cmd_i(sd_cmd_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic [1:0]   rmode;
    logic [1:0]   dmode;
    int           kind;        // 0 card silent, 1 short reply, 2 long reply
    logic [5:0]   r_idx;
    logic [31:0]  status;
    logic [119:0] cid;
    logic         bad_crc;
    logic         end_bit;
    logic [47:0]  frame;       // expected command frame
    int           hold;        // strobes to withhold ack per word
    int           total_b;     // expected SD clock bits in transaction
    int           sd_at;       // bit count when start_dat seen, -1 none
    logic         e_tmo;
    logic         e_crc;
    logic         e_end;
  } vec_t;

  vec_t vec[11];

  int checks = 0;
  int errors = 0;

  // monitor / card model state
  bit          card_q[$];
  logic [31:0] exp_q[$];
  int          b_count = 0;
  int          tx_cnt = 0;
  logic [47:0] tx_word = 48'd0;
  int          sd_first = -1;
  int          sd_w = 0;
  int          words_got = 0;
  int          hold_strobes = 0;
  int          hold_cnt = 0;
  int          word_b = 0;
  bit          word_pending = 1'b0;
  bit          strb_ph = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference CRC7 by augmented polynomial division over the low n bits of d.
  function automatic logic [6:0] crc7_ref(input logic [119:0] d, input int n);
    logic [7:0] r;
    r = 8'd0;
    for (int i = n - 1; i >= 0; i--) begin
      r = {r[6:0], d[i]};
      if (r[7]) r = r ^ 8'h89;
    end
    for (int i = 0; i < 7; i++) begin
      r = {r[6:0], 1'b0};
      if (r[7]) r = r ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    h = {2'b01, idx, arg};
    return {h, crc7_ref({80'd0, h}, 40), 1'b1};
  endfunction

  task automatic set_vec(input int i, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [1:0] rm, input logic [1:0] dm, input int kind,
                         input logic [5:0] ridx, input logic [31:0] st, input logic [119:0] cid,
                         input logic bad, input logic endb, input logic [47:0] frame,
                         input int hold, input int total, input int sd,
                         input logic et, input logic ec, input logic ee);
    vec[i].idx = idx; vec[i].arg = arg; vec[i].rmode = rm; vec[i].dmode = dm;
    vec[i].kind = kind; vec[i].r_idx = ridx; vec[i].status = st; vec[i].cid = cid;
    vec[i].bad_crc = bad; vec[i].end_bit = endb;
    vec[i].frame = (frame == 48'd0) ? cmd_frame(idx, arg) : frame;
    vec[i].hold = hold; vec[i].total_b = total; vec[i].sd_at = sd;
    vec[i].e_tmo = et; vec[i].e_crc = ec; vec[i].e_end = ee;
  endtask

  // Strobe/clock-enable generation, command capture, card replies, response ack.
  initial begin
    forever begin
      @(negedge clk_i);
      strb_ph     = ~strb_ph;
      clkstrb_i   = strb_ph;
      sd_clk_en_i = ~sd_clk_stall_o;
      if (start_dat_o) begin
        if (sd_first < 0) sd_first = b_count;
        sd_w++;
      end
      if (resp_ack_i) begin
        if (!resp_valid_o) resp_ack_i = 1'b0;
      end else if (resp_valid_o) begin
        if (!word_pending) begin
          word_pending = 1'b1;
          hold_cnt = 0;
          word_b = b_count;
        end
        if (hold_cnt >= hold_strobes) begin
          words_got++;
          check("stall_held", {63'd0, sd_clk_stall_o}, 64'd1);
          check("no_shift_in_stall", 64'(b_count), 64'(word_b));
          if (exp_q.size() == 0) begin
            check("extra_word", 64'(resp_data_o), 64'hDEAD_DEAD_DEAD_DEAD);
          end else begin
            check("resp_word", {32'd0, resp_data_o}, {32'd0, exp_q.pop_front()});
          end
          resp_ack_i = 1'b1;
          word_pending = 1'b0;
        end else if (clkstrb_i) begin
          hold_cnt++;
        end
      end
      if (clkstrb_i && sd_clk_en_i && sd_clk_req_o) begin
        b_count++;
        if (sd_cmd_oe) begin
          tx_word = {tx_word[46:0], sd_cmd_o};
          tx_cnt++;
        end else if (card_q.size() > 0) begin
          sd_cmd_i = card_q.pop_front();
        end else begin
          sd_cmd_i = 1'b1;
        end
      end
    end
  end

  task automatic run_txn(input vec_t v, input string tag);
    logic [47:0]  r48;
    logic [135:0] r136;
    logic [6:0]   c;
    int           nwords;
    card_q.delete();
    exp_q.delete();
    nwords = 0;
    if (v.kind == 1) begin
      c = crc7_ref({80'd0, 2'b00, v.r_idx, v.status}, 40);
      if (v.bad_crc) c[0] = ~c[0];
      r48 = {2'b00, v.r_idx, v.status, c, v.end_bit};
      for (int i = 0; i < 5; i++) card_q.push_back(1'b1);
      for (int i = 47; i >= 0; i--) card_q.push_back(r48[i]);
      exp_q.push_back(v.status);
      nwords = 1;
    end else if (v.kind == 2) begin
      c = crc7_ref(v.cid, 120);
      if (v.bad_crc) c[0] = ~c[0];
      r136 = {2'b00, 6'h3F, v.cid, c, v.end_bit};
      for (int i = 0; i < 5; i++) card_q.push_back(1'b1);
      for (int i = 135; i >= 0; i--) card_q.push_back(r136[i]);
      for (int k = 0; k < 4; k++) exp_q.push_back(r136[127 - 32*k -: 32]);
      nwords = 4;
    end
    hold_strobes = v.hold;
    @(negedge clk_i);
    b_count = 0; tx_cnt = 0; tx_word = 48'd0; sd_first = -1; sd_w = 0; words_got = 0;
    cmd_idx_i = v.idx; cmd_arg_i = v.arg; cmd_crc_i = 7'h55;
    ctrl_rmode_i = v.rmode; ctrl_dmode_i = v.dmode;
    ctrl_start_i = 1'b1;
    for (int k = 0; k < 20 && status_idle_o; k++) @(negedge clk_i);
    // Inputs change while start is still held: must not be re-latched.
    cmd_idx_i = ~v.idx; cmd_arg_i = ~v.arg;
    for (int k = 0; k < 100 && tx_cnt < 4; k++) @(negedge clk_i);
    ctrl_start_i = 1'b0;
    for (int k = 0; k < 4000 && !status_idle_o; k++) @(negedge clk_i);
    check({tag, "_done_idle"}, {63'd0, status_idle_o}, 64'd1);
    check({tag, "_frame"}, {16'd0, tx_word}, {16'd0, v.frame});
    check({tag, "_tx_bits"}, 64'(tx_cnt), 64'd48);
    check({tag, "_total_b"}, 64'(b_count), 64'(v.total_b));
    check({tag, "_err_tmo"}, {63'd0, err_timeout_o}, {63'd0, v.e_tmo});
    check({tag, "_err_crc"}, {63'd0, err_crc_o}, {63'd0, v.e_crc});
    check({tag, "_err_end"}, {63'd0, err_end_o}, {63'd0, v.e_end});
    check({tag, "_sd_at"}, 64'(sd_first), 64'(v.sd_at));
    check({tag, "_sd_width"}, 64'(sd_w), (v.sd_at < 0) ? 64'd0 : 64'd2);
    check({tag, "_words"}, 64'(words_got), 64'(nwords));
    check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_req_low"}, {63'd0, sd_clk_req_o}, 64'd0);
    if (v.kind == 1) check({tag, "_resp_idx"}, {58'd0, resp_idx_o}, {58'd0, v.r_idx});
  endtask

  initial begin
    // idx arg rmode dmode kind ridx status cid bad end frame hold total sd tmo crc end
    set_vec(0, 6'd0, 32'h0, 2'd0, 2'd0, 0, 6'd0, 32'h0, 120'h0, 1'b0, 1'b1,
            48'h400000000095, 0, 56, -1, 1'b0, 1'b0, 1'b0);
    set_vec(1, 6'd8, 32'h000001AA, 2'd1, 2'd0, 1, 6'd8, 32'h000001AA, 120'h0, 1'b0, 1'b1,
            48'h48000001AA87, 0, 109, -1, 1'b0, 1'b0, 1'b0);
    set_vec(2, 6'd13, 32'h12340000, 2'd1, 2'd0, 0, 6'd0, 32'h0, 120'h0, 1'b0, 1'b1,
            48'd0, 0, 48 + NCR + TAIL, -1, 1'b1, 1'b0, 1'b0);
    set_vec(3, 6'd2, 32'h0, 2'd2, 2'd0, 2, 6'd0, 32'h0,
            120'h035344_534431_3238_80_1234ABCD_0145, 1'b0, 1'b1, 48'd0, 20, 197, -1, 1'b0, 1'b0, 1'b0);
    set_vec(4, 6'd2, 32'h0, 2'd2, 2'd0, 2, 6'd0, 32'h0,
            120'h1BADC0_FFEE00_1122_33_44556677_8899, 1'b1, 1'b1, 48'd0, 20, 197, -1, 1'b0, 1'b1, 1'b0);
    set_vec(5, 6'd41, 32'h40FF8000, 2'd3, 2'd0, 1, 6'h3F, 32'h80FF8000, 120'h0, 1'b1, 1'b1,
            48'd0, 0, 109, -1, 1'b0, 1'b0, 1'b0);
    set_vec(6, 6'd17, 32'h00000200, 2'd1, 2'd2, 1, 6'd17, 32'h00000900, 120'h0, 1'b0, 1'b1,
            48'd0, 0, 109, 48, 1'b0, 1'b0, 1'b0);
    set_vec(7, 6'd24, 32'h00000400, 2'd1, 2'd3, 1, 6'd24, 32'h00000900, 120'h0, 1'b0, 1'b1,
            48'd0, 3, 109, 101, 1'b0, 1'b0, 1'b0);
    set_vec(8, 6'd12, 32'h0, 2'd1, 2'd1, 1, 6'd12, 32'h00000B00, 120'h0, 1'b0, 1'b0,
            48'd0, 0, 109, 101, 1'b0, 1'b0, 1'b1);
    set_vec(9, 6'd25, 32'hCAFEF00D, 2'd0, 2'd3, 0, 6'd0, 32'h0, 120'h0, 1'b0, 1'b1,
            48'd0, 0, 56, 48, 1'b0, 1'b0, 1'b0);
    set_vec(10, 6'd9, 32'h00010000, 2'd2, 2'd3, 2, 6'd0, 32'h0,
            120'hA5A5A5_5A5A5A_0F0F_F0_DEADBEEF_7777, 1'b0, 1'b1, 48'd0, 0, 197, 189, 1'b0, 1'b0, 1'b0);

    // reset state
    repeat (4) @(negedge clk_i);
    check("rst_idle", {63'd0, status_idle_o}, 64'd1);
    check("rst_outs", {55'd0, resp_valid_o, err_timeout_o, err_crc_o, err_end_o,
                       start_dat_o, sd_clk_req_o, sd_clk_stall_o, sd_cmd_oe, sd_cmd_o}, 64'd1);
    check("rst_data", {26'd0, resp_idx_o, resp_data_o}, 64'd0);
    rstn_i = 1'b1;
    repeat (4) @(negedge clk_i);

    for (int i = 0; i < 11; i++) begin
      run_txn(vec[i], $sformatf("v%0d", i));
    end

    // asynchronous reset in the middle of a command
    @(negedge clk_i);
    tx_cnt = 0;
    cmd_idx_i = 6'd17; cmd_arg_i = 32'h55AA55AA; ctrl_rmode_i = 2'd1; ctrl_dmode_i = 2'd0;
    ctrl_start_i = 1'b1;
    for (int k = 0; k < 500 && tx_cnt < 20; k++) @(negedge clk_i);
    ctrl_start_i = 1'b0;
    check("mid_write_oe", {63'd0, sd_cmd_oe}, 64'd1);
    #2 rstn_i = 1'b0;
    #1;
    check("arst_oe", {63'd0, sd_cmd_oe}, 64'd0);
    check("arst_req", {63'd0, sd_clk_req_o}, 64'd0);
    check("arst_idle", {63'd0, status_idle_o}, 64'd1);
    check("arst_cmd", {63'd0, sd_cmd_o}, 64'd1);
    @(negedge clk_i);
    rstn_i = 1'b1;
    repeat (2) @(negedge clk_i);
    run_txn(vec[1], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
